// File: rtl/i2s_tx_slave.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_slave
//  Description : Slave-mode I2S transmitter following an external ws/sck pair,
//                fed with stereo frames through a small valid/ready frame FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_slave #(
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en,
    input  logic                          ws,
    input  logic                          sck,
    output logic                          sdi,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_W-1:0]           s_left,
    input  logic [SAMPLE_W-1:0]           s_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);

    localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                 c_LVL_W   = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL    = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE = c_LVL_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic                r_ws_s1, r_ws_s2, r_ws_last;
    logic                r_sck_s1, r_sck_s2, r_sck_prev;
    logic                r_active;
    logic                r_sdi;
    logic                r_underrun;
    logic [SAMPLE_W-1:0] r_shreg;
    logic [SAMPLE_W-1:0] r_held_right;
    logic [c_PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic [SAMPLE_W-1:0] r_fifo_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] r_fifo_r [FIFO_DEPTH];

    logic w_fall, w_boundary, w_frame_start, w_empty, w_push, w_pop;

    assign w_fall        = r_sck_prev & ~r_sck_s2;
    assign w_boundary    = w_fall & (r_ws_s2 != r_ws_last);
    assign w_frame_start = w_boundary & ~r_ws_s2;
    assign w_empty       = (r_level == '0);
    assign w_pop         = w_frame_start & en & ~w_empty;
    assign w_push        = s_valid & s_ready;

    assign s_ready    = (r_level != c_FULL);
    assign fifo_level = r_level;
    assign sdi        = r_sdi;
    assign underrun   = r_underrun;

    // Serial side: synchronisers, falling-edge detect, shifter and word loading
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ws_s1      <= 1'b0;
            r_ws_s2      <= 1'b0;
            r_ws_last    <= 1'b0;
            r_sck_s1     <= 1'b0;
            r_sck_s2     <= 1'b0;
            r_sck_prev   <= 1'b0;
            r_active     <= 1'b0;
            r_sdi        <= 1'b0;
            r_underrun   <= 1'b0;
            r_shreg      <= '0;
            r_held_right <= '0;
        end else begin
            r_ws_s1    <= ws;
            r_ws_s2    <= r_ws_s1;
            r_sck_s1   <= sck;
            r_sck_s2   <= r_sck_s1;
            r_sck_prev <= r_sck_s2;
            r_underrun <= 1'b0;
            if (w_fall) begin
                r_sdi     <= r_shreg[SAMPLE_W-1];
                r_ws_last <= r_ws_s2;
                if (w_frame_start) begin
                    r_active <= en;
                    if (en && !w_empty) begin
                        r_shreg      <= r_fifo_l[r_rd_ptr];
                        r_held_right <= r_fifo_r[r_rd_ptr];
                    end else begin
                        r_shreg      <= '0;
                        r_held_right <= '0;
                        r_underrun   <= en;
                    end
                end else if (w_boundary) begin
                    r_shreg <= r_active ? r_held_right : '0;
                end else begin
                    r_shreg <= r_shreg << 1;
                end
            end
        end
    end

    // Frame FIFO control; a pop that sees empty leaves a same-cycle push stored
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - c_LVL_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_l[r_wr_ptr] <= s_left;
            r_fifo_r[r_wr_ptr] <= s_right;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx_slave
//  Description : Bench for i2s_tx_slave: I2S master model, receiver monitor
//                and per-frame expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_slave;

    localparam int SAMPLE_W   = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int H          = 6;   // clk cycles per sck half period

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        en = 1'b0;
    logic        ws = 1'b1;
    logic        sck = 1'b1;
    logic        s_valid = 1'b0;
    logic [23:0] s_left = '0;
    logic [23:0] s_right = '0;
    logic        sdi;
    logic        s_ready;
    logic [2:0]  fifo_level;
    logic        underrun;

    i2s_tx_slave #(.SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .en(en), .ws(ws), .sck(sck), .sdi(sdi),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .fifo_level(fifo_level), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [23:0] l;
        logic [23:0] r;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   frame_cnt = 0;
    int   bit_pos = 0;
    int   mon_start = 32'h4000_0000;
    int   ur_cnt = 0;
    int   ur_long = 0;
    bit   master_go = 1'b0;
    event frame_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input int n);
        while (frame_cnt < n) @(frame_ev);
    endtask

    task automatic sb_add(input int idx, input logic [23:0] l, input logic [23:0] r);
        exp_t e;
        e.idx = idx;
        e.l   = l;
        e.r   = r;
        sb.push_back(e);
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL push_timeout: s_ready stayed %b, required 1", s_ready);
    endtask

    // I2S master: ws changes on sck falling edges, 32 sck per channel
    initial begin
        wait (master_go);
        forever begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int b = 0; b < 32; b++) begin
                    @(posedge clk);
                    #1;
                    sck = 1'b0;
                    if (b == 0) begin
                        ws = (ch == 1);
                        if (ch == 0) begin
                            frame_cnt++;
                            ->frame_ev;
                        end
                    end
                    bit_pos = ch * 32 + b;
                    repeat (H) @(posedge clk);
                    #1 sck = 1'b1;
                    repeat (H - 1) @(posedge clk);
                end
            end
        end
    end

    // Receiver monitor: sdi captured on sck rising; the bit at a ws change is
    // the last bit of the previous word, so each word is 32 bits long.
    initial begin
        logic        ws_prev;
        logic [31:0] acc;
        logic [31:0] word;
        logic [31:0] left_word;
        int          idx;
        exp_t        e;
        ws_prev   = 1'b1;
        acc       = '0;
        left_word = '0;
        forever begin
            @(posedge sck);
            if (ws != ws_prev) begin
                word = {acc[30:0], sdi};
                if (ws) begin
                    left_word = word;
                end else begin
                    idx = frame_cnt - 1;
                    if (idx >= mon_start) begin
                        while (sb.size() > 0 && sb[0].idx < idx) begin
                            e = sb.pop_front();
                            chk("frame_missed", idx, e.idx);
                        end
                        if (sb.size() > 0 && sb[0].idx == idx) begin
                            e = sb.pop_front();
                        end else begin
                            e.idx = idx;
                            e.l   = '0;
                            e.r   = '0;
                        end
                        chk($sformatf("left_word[f%0d]", idx), left_word, {e.l, 8'h00});
                        chk($sformatf("right_word[f%0d]", idx), word, {e.r, 8'h00});
                    end
                end
                acc = '0;
            end else begin
                acc = {acc[30:0], sdi};
            end
            ws_prev = ws;
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (underrun) begin
                ur_cnt++;
                if (prev) ur_long++;
            end
            prev = underrun;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int u;
        logic [23:0] d_l [4];
        logic [23:0] d_r [4];
        d_l[0] = 24'h123456; d_r[0] = 24'h654321;
        d_l[1] = 24'hABCDEF; d_r[1] = 24'hFEDCBA;
        d_l[2] = 24'h800001; d_r[2] = 24'h7FFFFE;
        d_l[3] = 24'hFFFFFF; d_r[3] = 24'h000000;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_sdi", sdi, 0);
        chk("reset_s_ready", s_ready, 1);
        chk("reset_level", fifo_level, 0);
        chk("reset_underrun", underrun, 0);
        #2 rst_i = 1'b0;
        tick(4);
        en = 1'b1;
        master_go = 1'b1;

        // basic frame with 8 trailing zero bits per channel
        @(frame_ev);
        c0 = frame_cnt;
        mon_start = c0 + 1;
        tick(10);
        push(24'hA5A5A5, 24'h5A5A5A);
        sb_add(c0 + 1, 24'hA5A5A5, 24'h5A5A5A);
        chk("level_after_push", fifo_level, 1);

        // fill the FIFO, hold off a fifth frame
        wait_frame(c0 + 1);
        tick(10);
        chk("level_after_pop", fifo_level, 0);
        for (int i = 0; i < 4; i++) begin
            push(d_l[i], d_r[i]);
            sb_add(c0 + 2 + i, d_l[i], d_r[i]);
        end
        chk("full_level", fifo_level, 4);
        chk("full_s_ready", s_ready, 0);
        s_left  = 24'hDEAD00;
        s_right = 24'h00BEEF;
        s_valid = 1'b1;
        tick(4);
        chk("held_off_level", fifo_level, 4);
        chk("held_off_s_ready", s_ready, 0);
        s_valid = 1'b0;
        wait_frame(c0 + 2);
        tick(10);
        chk("level_after_full_pop", fifo_level, 3);
        chk("s_ready_after_full_pop", s_ready, 1);

        // underrun on an empty FIFO
        wait_frame(c0 + 5);
        tick(10);
        u = ur_cnt;
        wait_frame(c0 + 6);
        tick(10);
        chk("underrun_pulses", ur_cnt, u + 1);
        chk("underrun_width", ur_long, 0);
        chk("underrun_level", fifo_level, 0);

        // disable mid-left: current frame intact, next frame silent
        push(24'h111111, 24'h222222);
        sb_add(c0 + 7, 24'h111111, 24'h222222);
        push(24'h333333, 24'h444444);
        wait_frame(c0 + 7);
        tick(50);
        en = 1'b0;
        chk("disable_level", fifo_level, 1);
        u = ur_cnt;
        wait_frame(c0 + 8);
        tick(10);
        chk("disabled_no_pop", fifo_level, 1);
        chk("disabled_no_underrun", ur_cnt, u);
        en = 1'b1;
        sb_add(c0 + 9, 24'h333333, 24'h444444);
        wait_frame(c0 + 9);
        tick(10);
        chk("reenable_pop", fifo_level, 0);

        // reset during right-channel bit 10
        push(24'h0F0F0F, 24'hF0F0F0);
        push(24'h777777, 24'h888888);
        chk("pre_reset_level2", fifo_level, 2);
        wait_frame(c0 + 10);
        tick(10);
        chk("pre_reset_level1", fifo_level, 1);
        for (int k = 0; k < 3000 && bit_pos != 42; k++) @(posedge clk);
        chk("reached_right_bit10", bit_pos, 42);
        tick(3);
        #2 rst_i = 1'b1;
        #1;
        chk("midreset_sdi", sdi, 0);
        chk("midreset_level", fifo_level, 0);
        chk("midreset_s_ready", s_ready, 1);
        mon_start = c0 + 11;
        tick(3);
        rst_i = 1'b0;
        tick(2);
        u = ur_cnt;
        push(24'hC3C3C3, 24'h3C3C3C);
        sb_add(c0 + 11, 24'hC3C3C3, 24'h3C3C3C);
        wait_frame(c0 + 11);
        tick(10);
        chk("post_reset_pop", fifo_level, 0);
        chk("post_reset_no_underrun", ur_cnt, u);

        // push landing on the frame-start cycle of an empty FIFO
        @(frame_ev);
        @(posedge clk);
        @(posedge clk);
        #1;
        s_left  = 24'h9A9A9A;
        s_right = 24'hA9A9A9;
        s_valid = 1'b1;
        u = ur_cnt;
        sb_add(c0 + 13, 24'h9A9A9A, 24'hA9A9A9);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("edge_push_underrun", underrun, 1);
        chk("edge_push_level", fifo_level, 1);
        wait_frame(c0 + 13);
        tick(10);
        chk("edge_push_popped", fifo_level, 0);
        chk("edge_push_single_underrun", ur_cnt, u + 1);

        wait_frame(c0 + 14);
        tick(20);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
